// File: rtl/time_splitter.sv
// Splits a 28-bit seconds count into days/hours/minutes/seconds/weekday
// using one shared restoring divider that produces one quotient bit per cycle.
module time_splitter #(
  parameter int unsigned EPOCH_WDAY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [27:0] t,
  output logic        busy,
  output logic        done,
  output logic [11:0] days,
  output logic [4:0]  hours,
  output logic [5:0]  minutes,
  output logic [5:0]  seconds,
  output logic [2:0]  weekday
);

  typedef enum logic [2:0] {IDLE, DIV_DAY, DIV_HOUR, DIV_MIN, DIV_WDAY, DONE} state_t;

  state_t      state_q, state_d;
  logic [27:0] dvd_q, dvd_d;
  logic [16:0] rem_q, rem_d;
  logic [27:0] quo_q, quo_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [11:0] day_q, day_d;
  logic [4:0]  hr_q, hr_d;
  logic [5:0]  mn_q, mn_d;
  logic [5:0]  sc_q, sc_d;
  logic [2:0]  wd_q, wd_d;
  logic [11:0] days_q, days_d;
  logic [4:0]  hours_q, hours_d;
  logic [5:0]  minutes_q, minutes_d;
  logic [5:0]  seconds_q, seconds_d;
  logic [2:0]  weekday_q, weekday_d;
  logic        done_q, done_d;

  logic [16:0] divisor;
  logic [17:0] trial;
  logic        take;
  logic [16:0] rem_step;
  logic [27:0] quo_step;

  // One restoring step: the shifted remainder needs 18 bits before the compare.
  always_comb begin
    divisor = 17'd86400;
    case (state_q)
      DIV_HOUR: divisor = 17'd3600;
      DIV_MIN:  divisor = 17'd60;
      DIV_WDAY: divisor = 17'd7;
      default:  divisor = 17'd86400;
    endcase
    trial    = {rem_q, dvd_q[27]};
    take     = (trial >= {1'b0, divisor});
    rem_step = take ? 17'(trial - {1'b0, divisor}) : trial[16:0];
    quo_step = {quo_q[26:0], take};
  end

  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    day_d     = day_q;
    hr_d      = hr_q;
    mn_d      = mn_q;
    sc_d      = sc_q;
    wd_d      = wd_q;
    days_d    = days_q;
    hours_d   = hours_q;
    minutes_d = minutes_q;
    seconds_d = seconds_q;
    weekday_d = weekday_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d   = t;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = 5'd27;
          state_d = DIV_DAY;
        end
      end
      DIV_DAY, DIV_HOUR, DIV_MIN, DIV_WDAY: begin
        dvd_d = {dvd_q[26:0], 1'b0};
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          // Each stage reloads the dividend left-aligned so bits feed MSB first.
          rem_d = '0;
          quo_d = '0;
          case (state_q)
            DIV_DAY: begin
              day_d   = quo_step[11:0];
              dvd_d   = {rem_step, 11'b0};
              cnt_d   = 5'd16;
              state_d = DIV_HOUR;
            end
            DIV_HOUR: begin
              hr_d    = quo_step[4:0];
              dvd_d   = {rem_step[11:0], 16'b0};
              cnt_d   = 5'd11;
              state_d = DIV_MIN;
            end
            DIV_MIN: begin
              mn_d    = quo_step[5:0];
              sc_d    = rem_step[5:0];
              dvd_d   = {day_q + 12'(EPOCH_WDAY), 16'b0};
              cnt_d   = 5'd11;
              state_d = DIV_WDAY;
            end
            default: begin
              wd_d    = rem_step[2:0];
              cnt_d   = 5'd0;
              state_d = DONE;
            end
          endcase
        end
      end
      DONE: begin
        days_d    = day_q;
        hours_d   = hr_q;
        minutes_d = mn_q;
        seconds_d = sc_q;
        weekday_d = wd_q;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      dvd_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      day_q     <= '0;
      hr_q      <= '0;
      mn_q      <= '0;
      sc_q      <= '0;
      wd_q      <= '0;
      days_q    <= '0;
      hours_q   <= '0;
      minutes_q <= '0;
      seconds_q <= '0;
      weekday_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      day_q     <= day_d;
      hr_q      <= hr_d;
      mn_q      <= mn_d;
      sc_q      <= sc_d;
      wd_q      <= wd_d;
      days_q    <= days_d;
      hours_q   <= hours_d;
      minutes_q <= minutes_d;
      seconds_q <= seconds_d;
      weekday_q <= weekday_d;
      done_q    <= done_d;
    end
  end

  // The done cycle is spent back in IDLE, so busy also covers done_q.
  assign busy    = (state_q != IDLE) || done_q;
  assign done    = done_q;
  assign days    = days_q;
  assign hours   = hours_q;
  assign minutes = minutes_q;
  assign seconds = seconds_q;
  assign weekday = weekday_q;

endmodule

// File: doc/time_splitter.md
Name: time_splitter

Overview:
- Downstream consumer of the 28-bit seconds counter `t`.
- Converts the raw seconds value into calendar-free display fields: day count, hours, minutes, seconds and weekday.
- Uses one shared iterative restoring divider, one quotient bit per cycle, so no wide combinational dividers are needed.
- Its outputs feed the display/BCD formatting stage.

Parameters:
- EPOCH_WDAY, 4, weekday of day 0 (0=Sunday .. 6=Saturday); 4 = Thursday (Unix epoch). Legal range 0..6.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset).
- start  input  1  conversion request; sampled only in IDLE.
- t  input  28  seconds value; captured into an internal register on the accepted start.
- busy  output  1  high from the cycle after an accepted start through the cycle done is high.
- done  output  1  one-cycle pulse; the field outputs were updated on the same edge.
- days  output  12  t / 86400 (0..3106).
- hours  output  5  (t mod 86400) / 3600 (0..23).
- minutes  output  6  (t mod 3600) / 60 (0..59).
- seconds  output  6  t mod 60 (0..59).
- weekday  output  3  (days + EPOCH_WDAY) mod 7 (0..6).

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; busy=0, done=0.
  - days, hours, minutes, seconds, weekday = 0.
  - Internal dividend, remainder, quotient and iteration counter = 0.
  - Reset has priority over everything, including mid-conversion; the partial result is discarded and outputs return to 0.
- States: IDLE, DIV_DAY, DIV_HOUR, DIV_MIN, DIV_WDAY, DONE.
- Restoring division step (one per cycle):
  - Shift in the next dividend bit, MSB first: rem = {rem, bit}.
  - If rem >= divisor: rem -= divisor and quotient bit = 1; else quotient bit = 0.
  - Remainder register is 17 bits; all compares are unsigned.
- Timing, with start accepted at edge k (IDLE, start=1):
  - Edge k: latch t_reg = t; go to DIV_DAY.
  - DIV_DAY: edges k+1..k+28, 28 iterations, divisor 86400 -> day quotient, day remainder (17 b).
  - DIV_HOUR: edges k+29..k+45, 17 iterations on the day remainder, divisor 3600 -> hours, remainder (12 b).
  - DIV_MIN: edges k+46..k+57, 12 iterations, divisor 60 -> minutes quotient, seconds remainder.
  - DIV_WDAY: edges k+58..k+69, 12 iterations on (day quotient + EPOCH_WDAY), divisor 7 -> weekday remainder.
  - Edge k+70: all five outputs register simultaneously, done=1 and busy=1 for exactly that cycle, then IDLE.
  - Fixed latency: 70 cycles, start edge to done edge.
- Output and input rules:
  - Outputs hold their last completed values at all other times; they never show partial results.
  - Changes on `t` after the start edge have no effect on the running conversion.
  - start while busy (any non-IDLE state) is ignored, not queued.
  - start held high continuously -> back-to-back conversions: the next start is accepted at the edge after DONE (k+71), re-sampling t.
- Widths:
  - day quotient + EPOCH_WDAY <= 3112, fits in 12 bits, no overflow.
  - No wrap of outputs for any 28-bit t.

Test Plan:
- Reset low 2 cycles, then t=0, start pulse -> done at start+70; days=0, 00:00:00, weekday=4; busy high cycles k+1..k+70.
- t=86399 -> days=0, hours=23, minutes=59, seconds=59, weekday=4. Then t=86400 -> days=1, 0:0:0, weekday=5.
- t=1000000 -> days=11, hours=13, minutes=46, seconds=40, weekday=1.
- t=268435455 (max) -> days=3106, hours=21, minutes=24, seconds=15, weekday=2.
- Stimulus:
  - Start with t=1000000.
  - At k+10, change t to 0 and pulse start again.
- Required response:
  - Exactly one done at k+70 with the t=1000000 fields.
  - Outputs unchanged until then.
- Conversion running; reset low at k+30 -> next edge all outputs 0, busy=0, done=0, no done pulse. After release, a new start gives a correct result at +70.
